ram4_arbiter: RTL
=================

RAM4_ARBITER -- requirements
Module: ram4_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the number of clock cycles the RAM is held selected per access (legal range 1..15).
REQ-002 clk  input  1  the block's single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low SHALL force the reset state immediately, independent of clk.
REQ-004 req0, req1  input  1 each  access request from requester 0/1, level, held high until the matching ack.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read; valid while reqN is high.
REQ-006 addr0, addr1  input  2 each  word address 0..3.
REQ-007 wdata0, wdata1  input  4 each  write data.
REQ-008 ack0, ack1  output  1 each  single-cycle completion pulse.
REQ-009 rdata  output  4  read data; valid in the cycle ackN is high after a read.
REQ-010 grant  output  2  one-hot owner: bit0 = requester 0, bit1 = requester 1; 00 when idle.
REQ-011 busy  output  1  high while an access is in progress (ACCESS or DONE).
REQ-012 ram_cs_n  output  1  RAM chip select, active-low.
REQ-013 ram_rw  output  1  RAM direction: 1 = write, 0 = read.
REQ-014 ram_addr  output  2  RAM word address.
REQ-015 ram_wdata  output  4  RAM write data.
REQ-016 ram_rdata  input  4  RAM read data.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-018 In IDLE, if any req is high at a rising edge, the block SHALL accept one request, latch its we/addr/wdata, set grant and enter ACCESS; otherwise it SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin on a 1-bit priority pointer.
  - Only one req high: that requester wins.
  - Both req high: the requester named by the pointer wins.
  - On every accept, the pointer SHALL move to the non-winning requester.
REQ-020 ACCESS SHALL last exactly WAIT_CYCLES cycles, using a 4-bit down-counter.
  - ram_cs_n = 0 throughout.
  - ram_rw, ram_addr and ram_wdata SHALL be driven from the latched values and held constant.
REQ-021 On the final ACCESS edge, the block SHALL capture ram_rdata into rdata (reads only) and enter DONE.
REQ-022 In DONE, the block SHALL assert the granted ack for exactly one cycle, drive ram_cs_n = 1, then return to IDLE.
REQ-023 Given acceptance at edge E, ack SHALL be high between edge E+WAIT_CYCLES and edge E+WAIT_CYCLES+1.
REQ-024 With a continuous request, acceptances SHALL be spaced WAIT_CYCLES+2 edges apart.
REQ-025 A requester SHALL deassert req at the edge that samples its ack; that req SHALL NOT be re-accepted before the following IDLE cycle.
REQ-026 req, we, addr and wdata changes during ACCESS/DONE SHALL NOT affect the access in flight.
REQ-027 A req that drops before being accepted SHALL be discarded with no RAM activity and no ack.
REQ-028 rdata SHALL hold its last captured value until the next read completes; writes SHALL NOT change it.
REQ-029 Outside ACCESS: ram_cs_n = 1, ram_rw = 0, ram_addr = 0, ram_wdata = 0.
REQ-030 ack0 and ack1 SHALL never be high together; grant SHALL be one-hot or zero.
REQ-031 Out-of-range WAIT_CYCLES values are unsupported; WAIT_CYCLES = 1 SHALL still give a one-cycle ACCESS.

Reset
REQ-032 While reset = 0, the block SHALL hold:
  - state IDLE, pointer = requester 0, counter 0;
  - ack0 = ack1 = 0, grant = 00, busy = 0;
  - ram_cs_n = 1, ram_rw = 0, ram_addr = 0, ram_wdata = 0, rdata = 0.
REQ-033 Reset asserted mid-ACCESS SHALL abort the access with no ack; ram_cs_n SHALL go high asynchronously.
REQ-034 After reset is released, the first accept SHALL occur at the first rising edge on which reset is high and a req is sampled.

Verification
REQ-035 W=2; req0 write addr 2, data 0xA at edge 0 -> ram_cs_n low cycles 0-1 with rw=1, addr=2, wdata=0xA; ack0 high cycle 2; grant=01 cycles 0-2.
REQ-036 Write 0xA to addr 2, then req1 read addr 2 (RAM model returns 0xA) -> ack1 high with rdata=0xA; grant=10.
REQ-037 req0 and req1 both held high out of reset -> served in order 0, 1, 0, 1; acceptances 4 edges apart; acks never overlap.
REQ-038 Reset pulsed low during the second ACCESS cycle -> ram_cs_n=1 and grant=00 immediately, no ack; after release, req1 alone is served normally.
REQ-039 W=1 with req1 continuous -> ack1 pulses every 3 cycles; ram_cs_n low exactly 1 cycle per access.
REQ-040 addr0/wdata0 toggled during ACCESS -> ram_addr/ram_wdata hold the latched values until DONE.

Source files
------------

// File: rtl/ram4_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a 4x4 RAM.
interface ram4_arbiter_if;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 4;

  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic [1:0]    grant;
  logic          busy;
  logic          ram_cs_n;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // Requesters and the RAM model drive this side
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  ack0, ack1, rdata, grant, busy, ram_cs_n, ram_rw, ram_addr, ram_wdata
  );

  // Arbiter side
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    output ack0, ack1, rdata, grant, busy, ram_cs_n, ram_rw, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram4_arbiter.sv
// Two-requester round-robin arbiter in front of a 4-word x 4-bit RAM.
// Each access holds the RAM selected for WAIT_CYCLES cycles, then pulses ack.
module ram4_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  ram4_arbiter_if.slave bus
);
  localparam int unsigned CW = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_ptr, w_ptr_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_ack0, w_ack0_nxt;
  logic          r_ack1, w_ack1_nxt;
  logic [DW-1:0] r_rdata, w_rdata_nxt;
  logic [1:0]    r_grant, w_grant_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_cs_n, w_cs_n_nxt;
  logic          r_rw, w_rw_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [DW-1:0] r_wdata, w_wdata_nxt;
  logic          w_any;
  logic          w_win;

  // A lone request always wins; the pointer only breaks ties
  assign w_any = bus.req0 | bus.req1;
  assign w_win = (bus.req0 & bus.req1) ? r_ptr : bus.req1;

  // Next-state and next-output logic; the RAM bus registers double as the latched request
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    w_rdata_nxt = r_rdata;
    w_grant_nxt = r_grant;
    w_busy_nxt  = r_busy;
    w_cs_n_nxt  = r_cs_n;
    w_rw_nxt    = r_rw;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;

    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = ACCESS;
          w_ptr_nxt   = ~w_win;
          w_cnt_nxt   = CW'(WAIT_CYCLES);
          w_grant_nxt = w_win ? 2'b10 : 2'b01;
          w_busy_nxt  = 1'b1;
          w_cs_n_nxt  = 1'b0;
          w_rw_nxt    = w_win ? bus.we1    : bus.we0;
          w_addr_nxt  = w_win ? bus.addr1  : bus.addr0;
          w_wdata_nxt = w_win ? bus.wdata1 : bus.wdata0;
        end
      end
      ACCESS: begin
        if (r_cnt <= CW'(1)) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
          if (!r_rw) begin
            w_rdata_nxt = bus.ram_rdata;
          end
          w_ack0_nxt  = r_grant[0];
          w_ack1_nxt  = r_grant[1];
          w_cs_n_nxt  = 1'b1;
          w_rw_nxt    = 1'b0;
          w_addr_nxt  = '0;
          w_wdata_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_grant_nxt = 2'b00;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = 2'b00;
        w_busy_nxt  = 1'b0;
        w_cs_n_nxt  = 1'b1;
        w_rw_nxt    = 1'b0;
        w_addr_nxt  = '0;
        w_wdata_nxt = '0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_cnt   <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_rdata <= '0;
      r_grant <= 2'b00;
      r_busy  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_rdata <= w_rdata_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= w_busy_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_rw    <= w_rw_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.rdata     = r_rdata;
  assign bus.grant     = r_grant;
  assign bus.busy      = r_busy;
  assign bus.ram_cs_n  = r_cs_n;
  assign bus.ram_rw    = r_rw;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
endmodule
